// File: rtl/hazard_control_unit.sv
// Hazard and stall controller for an in-order RV32I pipeline: load-use, multi-cycle EX, flush, memory stalls.
// Optional per-cause stall counters are enabled by defining HAZARD_PERF_EN.
module hazard_control_unit #(
    parameter int NUM_STAGES       = 4,
    parameter int REG_ADDR_W       = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int FLUSH_CYCLES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  ex_is_load,
    input  logic                  ex_busy,
    input  logic                  redirect,
    input  logic                  mem_stall,
    output logic                  load_pc,
    output logic [NUM_STAGES-1:0] load_stage,
    output logic [NUM_STAGES-1:0] bubble_stage,
    output logic [2:0]            stall_cause,
    input  logic [1:0]            perf_sel,
    output logic [31:0]           perf_data
);

    typedef enum logic [1:0] {ST_RUN, ST_LU, ST_FLUSH} state_e;
    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_LU    = 3'd1,
        CAUSE_MC    = 3'd2,
        CAUSE_FLUSH = 3'd3,
        CAUSE_MEM   = 3'd4
    } cause_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       flush_pend_q, flush_pend_d;

    logic   rs1_hit, rs2_hit, lu_hazard;
    logic   flush_now, flush_active, lu_active;
    cause_e cause;

    assign rs1_hit   = rs1_used && (rs1_id == rd_ex);
    assign rs2_hit   = rs2_used && (rs2_id == rd_ex);
    assign lu_hazard = ex_is_load && (rd_ex != '0) && (rs1_hit || rs2_hit);

    // A flush deferred by a memory stall fires on the first cycle memory is ready again.
    assign flush_now    = !mem_stall && (redirect || flush_pend_q);
    assign flush_active = flush_now || (state_q == ST_FLUSH);
    assign lu_active    = (state_q == ST_LU) || ((state_q == ST_RUN) && lu_hazard);

    always_comb begin
        if (mem_stall)         cause = CAUSE_MEM;
        else if (flush_active) cause = CAUSE_FLUSH;
        else if (ex_busy)      cause = CAUSE_MC;
        else if (lu_active)    cause = CAUSE_LU;
        else                   cause = CAUSE_NONE;
    end

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        load_pc      = 1'b1;
        load_stage   = '1;
        bubble_stage = '0;
        unique case (cause)
            CAUSE_MEM: begin
                load_pc    = 1'b0;
                load_stage = '0;
            end
            CAUSE_FLUSH: begin
                bubble_stage[1:0] = 2'b11;
            end
            CAUSE_MC: begin
                load_pc         = 1'b0;
                load_stage[1:0] = 2'b00;
                bubble_stage[2] = 1'b1;
            end
            CAUSE_LU: begin
                load_pc         = 1'b0;
                load_stage[0]   = 1'b0;
                bubble_stage[1] = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            load_pc      = 1'b0;
            load_stage   = '0;
            bubble_stage = '0;
        end
    end

    assign stall_cause = rst_n ? 3'(cause) : 3'd0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = mem_stall ? (flush_pend_q || redirect) : 1'b0;
        if (mem_stall) begin
            state_d = state_q;
        end else if (flush_now) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = 3'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        end else if (state_q == ST_FLUSH) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_d = ST_RUN;
        end else if (ex_busy) begin
            state_d = state_q;
        end else if (state_q == ST_LU) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_d = ST_RUN;
        end else if (lu_hazard && (LOAD_USE_BUBBLES > 1)) begin
            state_d = ST_LU;
            cnt_d   = 3'(LOAD_USE_BUBBLES - 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= 3'd0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q [4];
    logic [31:0] perf_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            perf_d[i] = perf_q[i];
            if ((3'(cause) == 3'(i + 1)) && (perf_q[i] != 32'hFFFF_FFFF))
                perf_d[i] = perf_q[i] + 32'd1;
        end
    end

    // NOTE: the counter array is only four words, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) perf_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) perf_q[i] <= perf_d[i];
        end
    end

    assign perf_data = perf_q[perf_sel];
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel;
    assign perf_data       = 32'd0;
`endif

endmodule
